// File: rtl/instr_sequencer.sv
// Run/Done instruction initiator: host FIFO feeding the CPU DIN bus.
// Issues one instruction (plus mvi immediate) and retires on Done.
module instr_sequencer #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 8
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iEnable,
    input  logic              iWr_en,
    input  logic [DATA_W-1:0] iWr_data,
    output logic              oFull,
    output logic              oEmpty,
    output logic              oOvf,
    input  logic              iDone,
    output logic              oRun,
    output logic [DATA_W-1:0] oDin,
    output logic              oBusy,
    output logic              oErr,
    output logic [7:0]        oRetired
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam logic [2:0] OP_MVI = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_IMM,
        S_WAIT,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wptr_q, rptr_q;
    logic [ADDR_W:0]   cnt_q;
    logic [DATA_W-1:0] din_q, din_d;
    logic [7:0]        ret_q, ret_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic              ovf_q;
    logic              push, pop;
    logic [DATA_W-1:0] head;
    logic [ADDR_W:0]   need;

    assign oFull  = (cnt_q == (ADDR_W+1)'(DEPTH));
    assign oEmpty = (cnt_q == '0);
    assign push   = iWr_en & ~oFull;
    assign head   = mem_q[rptr_q];
    // An mvi may only start once its immediate is already queued behind it
    assign need   = (head[8:6] == OP_MVI) ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1);

    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        ret_d   = ret_q;
        tmr_d   = tmr_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (iEnable && cnt_q >= need) begin
                    pop     = 1'b1;
                    din_d   = head;
                    tmr_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmr_d = tmr_q + TW'(1);
                if (din_q[8:6] == OP_MVI) begin
                    pop     = 1'b1;
                    din_d   = head;
                    state_d = S_IMM;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_IMM, S_WAIT: begin
                tmr_d = tmr_q + TW'(1);
                if (iDone) begin
                    ret_d   = ret_q + 8'd1;
                    state_d = S_IDLE;
                end else if (tmr_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= S_IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            din_q   <= '0;
            ret_q   <= '0;
            tmr_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            din_q   <= din_d;
            ret_q   <= ret_d;
            tmr_q   <= tmr_d;
            if (iWr_en && oFull) ovf_q <= 1'b1;
            if (push) wptr_q <= wptr_q + ADDR_W'(1);
            if (pop)  rptr_q <= rptr_q + ADDR_W'(1);
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + (ADDR_W+1)'(1);
                2'b01:   cnt_q <= cnt_q - (ADDR_W+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (push) mem_q[wptr_q] <= iWr_data;
    end

    assign oRun     = (state_q == S_ISSUE) || (state_q == S_IMM) ||
                      (state_q == S_WAIT);
    assign oBusy    = oRun;
    assign oErr     = (state_q == S_ERR);
    assign oDin     = din_q;
    assign oOvf     = ovf_q;
    assign oRetired = ret_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with an issue-order scoreboard
// and a Done responder of programmable latency.
module tb_instr_sequencer;
    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic        iEnable = 1'b0;
    logic        iWr_en = 1'b0;
    logic [15:0] iWr_data = '0;
    logic        iDone = 1'b0;
    logic        oFull, oEmpty, oOvf, oRun, oBusy, oErr;
    logic [15:0] oDin;
    logic [7:0]  oRetired;

    int nvec = 0;
    int nerr = 0;
    int done_lat = 1;
    int age = 0;
    int run_len = 0;
    logic        prev_run = 1'b0;
    logic [15:0] cur_instr = '0;
    logic [15:0] exp_q[$];

    instr_sequencer dut (
        .iClk(iClk), .iRst(iRst), .iEnable(iEnable),
        .iWr_en(iWr_en), .iWr_data(iWr_data),
        .oFull(oFull), .oEmpty(oEmpty), .oOvf(oOvf),
        .iDone(iDone), .oRun(oRun), .oDin(oDin),
        .oBusy(oBusy), .oErr(oErr), .oRetired(oRetired)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic sb_check(input logic [15:0] got);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            chk("unexpected_issue", 32'(got), 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            chk("issue_order", 32'(got), 32'(e));
        end
    endtask

    // Done responder and issue monitor
    initial begin
        forever begin
            @(negedge iClk);
            if (oRun) begin
                age = prev_run ? age + 1 : 0;
                if (age == 0) begin
                    cur_instr = oDin;
                    sb_check(oDin);
                end else if (age == 1 && cur_instr[8:6] == 3'b001) begin
                    sb_check(oDin);
                end
            end else if (prev_run) begin
                run_len = age + 1;
            end
            prev_run = oRun;
            iDone = oRun && (age == done_lat);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge iClk);
    endtask

    task automatic push(input logic [15:0] w, input bit accept);
        iWr_en = 1'b1;
        iWr_data = w;
        @(negedge iClk);
        iWr_en = 1'b0;
        if (accept) exp_q.push_back(w);
    endtask

    task automatic reset_dut();
        iRst = 1'b1;
        @(negedge iClk);
        iRst = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_rst(input string t);
        chk({t, "_run"}, 32'(oRun), 32'd0);
        chk({t, "_din"}, 32'(oDin), 32'd0);
        chk({t, "_busy"}, 32'(oBusy), 32'd0);
        chk({t, "_err"}, 32'(oErr), 32'd0);
        chk({t, "_ovf"}, 32'(oOvf), 32'd0);
        chk({t, "_ret"}, 32'(oRetired), 32'd0);
        chk({t, "_empty"}, 32'(oEmpty), 32'd1);
        chk({t, "_full"}, 32'(oFull), 32'd0);
    endtask

    task automatic wait_run(input int max);
        bit seen = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge iClk);
            if (oRun) begin
                seen = 1;
                break;
            end
        end
        chk("wait_run_timeout", 32'(seen), 32'd1);
    endtask

    task automatic wait_drain(input int max);
        bit ok = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge iClk);
            if (!oRun && oEmpty && exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        @(negedge iClk);
        chk("drain_timeout", 32'(ok), 32'd1);
    endtask

    initial begin
        tick(2);
        reset_dut();
        check_rst("rst0");

        // mv: Done one cycle after ISSUE
        done_lat = 1;
        iEnable = 1'b1;
        push(16'h000A, 1);
        wait_drain(20);
        chk("mv_runlen", 32'(run_len), 32'd2);
        chk("mv_din", 32'(oDin), 32'h000A);
        chk("mv_ret", 32'(oRetired), 32'd1);
        chk("mv_empty", 32'(oEmpty), 32'd1);

        // mvi stalls until the immediate arrives
        reset_dut();
        push(16'h0058, 1);
        tick(3);
        chk("mvi_stall_run", 32'(oRun), 32'd0);
        chk("mvi_stall_busy", 32'(oBusy), 32'd0);
        chk("mvi_stall_empty", 32'(oEmpty), 32'd0);
        push(16'h1234, 1);
        wait_drain(20);
        chk("mvi_runlen", 32'(run_len), 32'd2);
        chk("mvi_din", 32'(oDin), 32'h1234);
        chk("mvi_ret", 32'(oRetired), 32'd1);

        // add: Done at T3, DIN stable for four cycles
        reset_dut();
        done_lat = 3;
        push(16'h008B, 1);
        wait_run(20);
        for (int k = 0; k < 4; k++) begin
            chk("add_run", 32'(oRun), 32'd1);
            chk("add_din", 32'(oDin), 32'h008B);
            tick(1);
        end
        chk("add_run_drop", 32'(oRun), 32'd0);
        wait_drain(20);
        chk("add_runlen", 32'(run_len), 32'd4);
        chk("add_ret", 32'(oRetired), 32'd1);

        // fill to full, overflow, then drain in order
        reset_dut();
        iEnable = 1'b0;
        done_lat = 1;
        for (int i = 0; i < 16; i++) push(16'hA000 | 16'(i), 1);
        chk("fill_full", 32'(oFull), 32'd1);
        chk("fill_ovf0", 32'(oOvf), 32'd0);
        push(16'hBEEF, 0);
        chk("ovf_set", 32'(oOvf), 32'd1);
        chk("ovf_full", 32'(oFull), 32'd1);
        iEnable = 1'b1;
        wait_drain(100);
        chk("fill_ret", 32'(oRetired), 32'd16);
        chk("ovf_sticky", 32'(oOvf), 32'd1);

        // timeout into ERR
        reset_dut();
        done_lat = 1000;
        push(16'h008B, 1);
        wait_run(20);
        tick(7);
        chk("to_err_early", 32'(oErr), 32'd0);
        chk("to_run_early", 32'(oRun), 32'd1);
        tick(1);
        chk("to_err", 32'(oErr), 32'd1);
        chk("to_run", 32'(oRun), 32'd0);
        chk("to_busy", 32'(oBusy), 32'd0);
        push(16'h0001, 0);
        chk("err_push_accept", 32'(oEmpty), 32'd0);
        tick(3);
        chk("err_sticky", 32'(oErr), 32'd1);
        reset_dut();
        check_rst("rst_err");

        // reset in WAIT of an add
        push(16'h008B, 1);
        wait_run(20);
        push(16'h0002, 0);
        chk("mid_wait_run", 32'(oRun), 32'd1);
        reset_dut();
        chk("mid_rst_run", 32'(oRun), 32'd0);
        chk("mid_rst_empty", 32'(oEmpty), 32'd1);
        chk("mid_rst_ret", 32'(oRetired), 32'd0);
        chk("mid_rst_busy", 32'(oBusy), 32'd0);

        // 256 retires wrap the counter
        done_lat = 1;
        for (int i = 0; i < 255; i++) begin
            push(16'(i & 63), 1);
            wait_drain(20);
        end
        chk("ret_255", 32'(oRetired), 32'd255);
        push(16'h0003, 1);
        wait_drain(20);
        chk("ret_wrap", 32'(oRetired), 32'd0);
        chk("final_err", 32'(oErr), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
